// File: rtl/stc_pkg.sv
// stc_pkg -- shared definitions for the sensitivity-time-control (STC) block.
//
// Contents:
//   stcState_t    sequencer state encoding (IDLE, RAMP, HOLD)
//   STC_STEPS     gain steps per attenuation level (2 with half-steps, else 1)
//   stcRampSteps  total gain steps in one ramp for a given initial attenuation
//
// Build option: define STC_INTERP_EN to enable the 1.5x half-step between
// successive power-of-two attenuation levels.
package stc_pkg;

    typedef enum logic [1:0] {
        STC_IDLE,
        STC_RAMP,
        STC_HOLD
    } stcState_t;

`ifdef STC_INTERP_EN
    localparam int unsigned STC_STEPS = 2;
`else
    localparam int unsigned STC_STEPS = 1;
`endif

    function automatic int unsigned stcRampSteps(input int unsigned attMax);
        return attMax * STC_STEPS;
    endfunction

endpackage

// File: rtl/stc_gain_seq.sv
// stc_gain_seq -- gain schedule sequencer for the STC block.
//
// After a trigger the attenuation starts at 2^-ATT_MAX and is relaxed one
// step every 2^STEP_LOG2 valid samples until unity gain is reached (HOLD).
// gainMask bit i set means the datapath adds (sample >> i).
//
// Parameters:
//   DW         sample width (mask width)
//   ATT_MAX    initial attenuation shift, 1..DW-2
//   STEP_LOG2  log2 of valid samples per gain step
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   trig       restart the ramp (wins over a coincident step)
//   vid_valid  a sample is accepted this cycle; only these advance the ramp
//   gainMask   registered gain mask applied to the sample of this cycle
//   stc_busy   high while in RAMP
//
// Build option: STC_INTERP_EN adds the half-step (mask bits s and s+1).
module stc_gain_seq
    import stc_pkg::*;
#(
    parameter int unsigned DW        = 12,
    parameter int unsigned ATT_MAX   = 10,
    parameter int unsigned STEP_LOG2 = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          trig,
    input  logic          vid_valid,
    output logic [DW-1:0] gainMask,
    output logic          stc_busy
);

    localparam int unsigned SW = $clog2(DW);
    localparam logic [SW-1:0] S_INIT = SW'(ATT_MAX);

    stcState_t            state, nState;
    logic [SW-1:0]        s, nS;
    logic [STEP_LOG2-1:0] cnt, nCnt;
    logic [DW-1:0]        nMask;
`ifdef STC_INTERP_EN
    logic                 half, nHalf;
`endif

    always_comb begin
        nState = state;
        nS     = s;
        nCnt   = cnt;
`ifdef STC_INTERP_EN
        nHalf  = half;
`endif
        if (trig) begin
            nState = STC_RAMP;
            nS     = S_INIT;
            nCnt   = '0;
`ifdef STC_INTERP_EN
            nHalf  = 1'b0;
`endif
        end else if (state == STC_RAMP && vid_valid) begin
            nCnt = cnt + STEP_LOG2'(1);
            if (cnt == '1) begin
`ifdef STC_INTERP_EN
                if (!half) begin
                    nHalf = 1'b1;
                end else begin
                    nHalf = 1'b0;
                    nS    = s - SW'(1);
                    if (s == SW'(1)) nState = STC_HOLD;
                end
`else
                nS = s - SW'(1);
                if (s == SW'(1)) nState = STC_HOLD;
`endif
            end
        end

        // Mask is built from the next state so it can be registered with it.
        nMask = '0;
        if (nState == STC_RAMP) begin
            nMask[nS] = 1'b1;
`ifdef STC_INTERP_EN
            if (nHalf) nMask[nS + SW'(1)] = 1'b1;
`endif
        end else begin
            nMask[0] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= STC_IDLE;
            s        <= S_INIT;
            cnt      <= '0;
`ifdef STC_INTERP_EN
            half     <= 1'b0;
`endif
            gainMask <= DW'(1);
            stc_busy <= 1'b0;
        end else begin
            state    <= nState;
            s        <= nS;
            cnt      <= nCnt;
`ifdef STC_INTERP_EN
            half     <= nHalf;
`endif
            gainMask <= nMask;
            stc_busy <= (nState == STC_RAMP);
        end
    end

endmodule

// File: rtl/stc_param.sv
// stc_param -- sensitivity-time-control attenuator for NCH video channels.
//
// A shared gain schedule (stc_gain_seq) attenuates every channel; each
// channel output is the sum of (vid_in >> i) over the set mask bits, with
// per-term truncation. Two-cycle latency, no backpressure.
//
// Parameters: DW (sample width), NCH (channels), ATT_MAX (initial shift,
//   1..DW-2), STEP_LOG2 (log2 valid samples per gain step).
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   trig            restart the attenuation ramp
//   vid_valid       vid_in holds a sample this cycle
//   vid_in          packed samples, channel c at [c*DW +: DW]
//   vid_out_valid   vid_out holds a processed sample (vid_valid delayed 2)
//   vid_out         attenuated samples, same packing; holds when not valid
//   stc_busy        high while the ramp is running
//
// Build option: STC_INTERP_EN enables the 1.5x half-steps.
module stc_param
    import stc_pkg::*;
#(
    parameter int unsigned DW        = 12,
    parameter int unsigned NCH       = 1,
    parameter int unsigned ATT_MAX   = 10,
    parameter int unsigned STEP_LOG2 = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig,
    input  logic              vid_valid,
    input  logic [NCH*DW-1:0] vid_in,
    output logic              vid_out_valid,
    output logic [NCH*DW-1:0] vid_out,
    output logic              stc_busy
);

    logic [DW-1:0] gainMask;
    logic [DW-1:0] maskQ;
    logic          validQ;

    stc_gain_seq #(
        .DW        (DW),
        .ATT_MAX   (ATT_MAX),
        .STEP_LOG2 (STEP_LOG2)
    ) uSeq (
        .clk       (clk),
        .rst_n     (rst_n),
        .trig      (trig),
        .vid_valid (vid_valid),
        .gainMask  (gainMask),
        .stc_busy  (stc_busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validQ        <= 1'b0;
            vid_out_valid <= 1'b0;
            maskQ         <= DW'(1);
        end else begin
            validQ        <= vid_valid;
            vid_out_valid <= validQ;
            maskQ         <= gainMask;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : gCh
        logic [DW-1:0] termQ [DW];
        logic [DW-1:0] sum;
        logic [DW-1:0] outQ;

        always_ff @(posedge clk) begin
            for (int unsigned i = 0; i < DW; i++) begin
                termQ[i] <= vid_in[c*DW +: DW] >> i;
            end
        end

        // Total gain never exceeds 1, so a DW-bit accumulator cannot overflow.
        always_comb begin
            sum = '0;
            for (int unsigned i = 0; i < DW; i++) begin
                if (maskQ[i]) sum = sum + termQ[i];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                outQ <= '0;
            end else if (validQ) begin
                outQ <= sum;
            end
        end

        assign vid_out[c*DW +: DW] = outQ;
    end

endmodule
